// File: rtl/seq_detect_arbiter.sv
// -----------------------------------------------------------------------------
// seq_detect_arbiter
//
// Shares one 1->2->3 symbol-sequence detector among N requester lanes. The
// detector is granted round-robin to one lane for a whole burst. It watches
// that lane's 2-bit symbols and counts completed 1,2,3 patterns. At end of
// burst it reports the lane index and the (saturating) hit count.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[N]     per-lane request, held high for the whole burst
//   vld[N]     per-lane symbol valid
//   num[2N]    per-lane 2-bit symbol, lane i on bits [2i+1:2i]
//   last[N]    per-lane end-of-burst marker, qualified by vld
//   gnt[N]     registered one-hot grant
//   busy       high while a burst is running or being reported
//   hit        one-cycle pulse when a 1,2,3 pattern completes
//   done       one-cycle pulse at end of a completed burst
//   done_id    lane that finished, valid with done, held afterwards
//   hit_cnt    hits counted in the burst, valid with done, held until next grant
//   dbg_state  current control state (0 IDLE, 1 RUN, 2 REPORT)
//
// Handshake: there is no back-pressure. The granted lane g transfers a
// symbol on every rising edge where vld[g] is high. last[g] only counts on
// such an edge. The lane keeps req[g] high from request until its burst ends.
// Dropping req[g] on an edge where vld[g] is low abandons the burst.
// -----------------------------------------------------------------------------
module seq_detect_arbiter #(
  parameter int N    = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req,
  input  logic [N-1:0]      vld,
  input  logic [2*N-1:0]    num,
  input  logic [N-1:0]      last,
  output logic [N-1:0]      gnt,
  output logic              busy,
  output logic              hit,
  output logic              done,
  output logic [IDW-1:0]    done_id,
  output logic [CNTW-1:0]   hit_cnt,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    D_S0 = 2'd0,
    D_S1 = 2'd1,
    D_S2 = 2'd2,
    D_S3 = 2'd3
  } det_t;

  state_t          r_state;
  det_t            r_det;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_gid;
  logic [N-1:0]    r_gnt;
  logic            r_busy;
  logic            r_hit;
  logic            r_done;
  logic [IDW-1:0]  r_done_id;
  logic [CNTW-1:0] r_hit_cnt;

  logic [N-1:0]    w_rot;
  logic [N-1:0]    w_first;
  logic [N-1:0]    w_pick_oh;
  logic [IDW-1:0]  w_pick_id;
  logic            w_vld;
  logic            w_last;
  logic            w_req;
  logic [1:0]      w_sym;
  logic [IDW-1:0]  w_next_ptr;
  det_t            w_det_nxt;
  logic            w_enter_s3;

  // Round-robin pick. Rotate req so that the pointer lane sits at bit 0.
  // Isolate the lowest set bit, then rotate that one-hot back into lane order.
  assign w_rot     = (req >> r_ptr) | (req << (N - int'(r_ptr)));
  assign w_first   = w_rot & (~w_rot + N'(1));
  assign w_pick_oh = (w_first << r_ptr) | (w_first >> (N - int'(r_ptr)));

  always_comb begin
    w_pick_id = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pick_oh[i]) w_pick_id = IDW'(i);
    end
  end

  // The grant is one-hot, so masking with it selects the granted lane's controls.
  assign w_vld  = |(vld  & r_gnt);
  assign w_last = |(last & r_gnt);
  assign w_req  = |(req  & r_gnt);
  assign w_sym  = num[{r_gid, 1'b0} +: 2];

  assign w_next_ptr = (r_gid == IDW'(N - 1)) ? '0 : r_gid + IDW'(1);

  // Pattern detector. A stray 1 always restarts the pattern.
  always_comb begin
    w_det_nxt = D_S0;
    case (r_det)
      D_S0: w_det_nxt = (w_sym == 2'd1) ? D_S1 : D_S0;
      D_S1: begin
        if (w_sym == 2'd2)      w_det_nxt = D_S2;
        else if (w_sym == 2'd1) w_det_nxt = D_S1;
        else                    w_det_nxt = D_S0;
      end
      D_S2: begin
        if (w_sym == 2'd3)      w_det_nxt = D_S3;
        else if (w_sym == 2'd1) w_det_nxt = D_S1;
        else                    w_det_nxt = D_S0;
      end
      D_S3: w_det_nxt = (w_sym == 2'd1) ? D_S1 : D_S0;
      default: w_det_nxt = D_S0;
    endcase
  end

  assign w_enter_s3 = (w_det_nxt == D_S3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_det     <= D_S0;
      r_ptr     <= '0;
      r_gid     <= '0;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_hit     <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= '0;
      r_hit_cnt <= '0;
    end else begin
      r_hit  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_state   <= ST_RUN;
            r_gnt     <= w_pick_oh;
            r_gid     <= w_pick_id;
            r_det     <= D_S0;
            r_hit_cnt <= '0;
            r_busy    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_vld) begin
            r_det <= w_det_nxt;
            if (w_enter_s3) begin
              r_hit <= 1'b1;
              if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNTW'(1);
            end
            if (w_last) begin
              r_state   <= ST_REPORT;
              r_done    <= 1'b1;
              r_done_id <= r_gid;
              r_gnt     <= '0;
            end
          end else if (!w_req) begin
            // Burst abandoned: release without a report.
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_next_ptr;
          end
        end
        ST_REPORT: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_ptr   <= w_next_ptr;
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign busy      = r_busy;
  assign hit       = r_hit;
  assign done      = r_done;
  assign done_id   = r_done_id;
  assign hit_cnt   = r_hit_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for seq_detect_arbiter. Two copies of the design share one stimulus:
// u_dut uses the default 4-bit counter and u_sat uses a 2-bit counter.
// A behavioural model predicts every output cycle by cycle. The model treats
// a hit as "the last three accepted symbols of the burst are 1,2,3".
// Directed bursts pin the model with hand-computed values.
// -----------------------------------------------------------------------------
module tb_seq_detect_arbiter;

  localparam int N      = 4;
  localparam int IDW    = 2;
  localparam int CNTW   = 4;
  localparam int CNTW_S = 2;
  localparam int NW     = 2 * N;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]  req  = '0;
  logic [N-1:0]  vld  = '0;
  logic [NW-1:0] num  = '0;
  logic [N-1:0]  last = '0;

  logic [N-1:0]      gnt, s_gnt;
  logic              busy, s_busy, hit, s_hit, done, s_done;
  logic [IDW-1:0]    done_id, s_done_id;
  logic [CNTW-1:0]   hit_cnt;
  logic [CNTW_S-1:0] s_hit_cnt;
  logic [1:0]        dbg_state, s_dbg_state;

  seq_detect_arbiter #(.N(N), .IDW(IDW), .CNTW(CNTW)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .vld(vld), .num(num), .last(last),
    .gnt(gnt), .busy(busy), .hit(hit), .done(done), .done_id(done_id),
    .hit_cnt(hit_cnt), .dbg_state(dbg_state)
  );

  seq_detect_arbiter #(.N(N), .IDW(IDW), .CNTW(CNTW_S)) u_sat (
    .clk(clk), .rst_n(rst_n), .req(req), .vld(vld), .num(num), .last(last),
    .gnt(s_gnt), .busy(s_busy), .hit(s_hit), .done(s_done), .done_id(s_done_id),
    .hit_cnt(s_hit_cnt), .dbg_state(s_dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int c, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  // ---------------- behavioural model ----------------
  int           m_lane = -1;   // granted lane, -1 when none
  bit           m_report = 1'b0;
  int           m_ptr = 0;
  int           m_cnt = 0;     // unsaturated hits in current burst
  int           m_h1 = 0, m_h2 = 0, m_hn = 0;  // last two accepted symbols
  logic [N-1:0] e_gnt = '0;
  bit           e_busy = 1'b0, e_hit = 1'b0, e_done = 1'b0;
  int           e_done_id = 0;

  int           n_lane, n_ptr, n_cnt, n_h1, n_h2, n_hn, n_done_id, n_sym;
  bit           n_report, n_busy, n_hit, n_done, n_found;
  logic [N-1:0] n_gnt;

  logic [IDW+CNTW-1:0] exp_q[$];

  always_comb begin
    n_lane = m_lane; n_report = m_report; n_ptr = m_ptr; n_cnt = m_cnt;
    n_h1 = m_h1; n_h2 = m_h2; n_hn = m_hn;
    n_gnt = e_gnt; n_busy = e_busy; n_hit = 1'b0; n_done = 1'b0;
    n_done_id = e_done_id; n_sym = 0; n_found = 1'b0;
    if (m_report) begin
      n_report = 1'b0; n_busy = 1'b0; n_ptr = (m_lane + 1) % N; n_lane = -1;
    end else if (m_lane < 0) begin
      for (int k = 0; k < N; k++) begin
        if (!n_found && req[(m_ptr + k) % N]) begin
          n_found = 1'b1;
          n_lane = (m_ptr + k) % N;
        end
      end
      if (n_found) begin
        n_cnt = 0; n_hn = 0; n_gnt = '0; n_gnt[n_lane] = 1'b1; n_busy = 1'b1;
      end
    end else if (vld[m_lane]) begin
      n_sym = int'(num[2*m_lane +: 2]);
      if (m_hn == 2 && m_h2 == 1 && m_h1 == 2 && n_sym == 3) begin
        n_hit = 1'b1;
        n_cnt = m_cnt + 1;
      end
      n_h2 = m_h1; n_h1 = n_sym; n_hn = (m_hn < 2) ? m_hn + 1 : 2;
      if (last[m_lane]) begin
        n_report = 1'b1; n_done = 1'b1; n_done_id = m_lane; n_gnt = '0;
      end
    end else if (!req[m_lane]) begin
      n_lane = -1; n_gnt = '0; n_busy = 1'b0; n_ptr = (m_lane + 1) % N;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lane <= -1; m_report <= 1'b0; m_ptr <= 0; m_cnt <= 0;
      m_h1 <= 0; m_h2 <= 0; m_hn <= 0;
      e_gnt <= '0; e_busy <= 1'b0; e_hit <= 1'b0; e_done <= 1'b0; e_done_id <= 0;
      exp_q.delete();
    end else begin
      m_lane <= n_lane; m_report <= n_report; m_ptr <= n_ptr; m_cnt <= n_cnt;
      m_h1 <= n_h1; m_h2 <= n_h2; m_hn <= n_hn;
      e_gnt <= n_gnt; e_busy <= n_busy; e_hit <= n_hit; e_done <= n_done;
      e_done_id <= n_done_id;
      if (n_done) exp_q.push_back({IDW'(n_done_id), CNTW'(sat(n_cnt, CNTW))});
    end
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  always @(negedge clk) begin
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("busy", 32'(busy), 32'(e_busy));
    check("hit", 32'(hit), 32'(e_hit));
    check("done", 32'(done), 32'(e_done));
    check("done_id", 32'(done_id), 32'(e_done_id));
    check("hit_cnt", 32'(hit_cnt), 32'(sat(m_cnt, CNTW)));
    check("sat_gnt", 32'(s_gnt), 32'(e_gnt));
    check("sat_done", 32'(s_done), 32'(e_done));
    check("sat_hit_cnt", 32'(s_hit_cnt), 32'(sat(m_cnt, CNTW_S)));
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_done unexpected done_id=%0d hit_cnt=%0d", done_id, hit_cnt);
      end else begin
        check("sb_done", 32'({done_id, hit_cnt}), 32'(exp_q.pop_front()));
      end
    end
  end

  // Observation counters used by the directed checks.
  int mon_hits = 0, mon_dones = 0, last_done_id = 0, last_cnt = 0, last_s_cnt = 0;
  always @(negedge clk) begin
    if (hit === 1'b1) mon_hits <= mon_hits + 1;
    if (done === 1'b1) begin
      mon_dones    <= mon_dones + 1;
      last_done_id <= int'(done_id);
      last_cnt     <= int'(hit_cnt);
      last_s_cnt   <= int'(s_hit_cnt);
    end
  end

  // ---------------- driver tasks ----------------
  logic [1:0] sym_buf [16];
  int         sym_len;

  // Drive the given lane exactly and put random noise on all other lanes.
  task automatic set_inputs(input int lane, input bit v, input logic [1:0] s, input bit l);
    logic [N-1:0]  nz_vld, nz_last;
    logic [NW-1:0] nz_num;
    nz_vld  = N'($urandom);
    nz_last = N'($urandom);
    nz_num  = NW'($urandom);
    nz_vld[lane]        = v;
    nz_last[lane]       = l;
    nz_num[2*lane +: 2] = s;
    vld  = nz_vld;
    last = nz_last;
    num  = nz_num;
  endtask

  task automatic wait_any(output int lane);
    lane = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        for (int j = 0; j < N; j++) if (gnt[j]) lane = j;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL grant_timeout no grant within 40 cycles t=%0t", $time);
  endtask

  task automatic run_burst(input int lane, input bit gaps);
    int g;
    req[lane] = 1'b1;
    set_inputs(lane, 1'b0, 2'd0, 1'b0);
    wait_any(g);
    check("burst_lane", 32'(g), 32'(lane));
    if (g != lane) begin
      req[lane] = 1'b0;
      return;
    end
    for (int i = 0; i < sym_len; i++) begin
      if (gaps && (i % 2 == 1)) begin
        set_inputs(lane, 1'b0, 2'($urandom), 1'b0);
        @(negedge clk);
      end
      set_inputs(lane, 1'b1, sym_buf[i], (i == sym_len - 1));
      @(negedge clk);
    end
    req[lane] = 1'b0;
    set_inputs(lane, 1'b0, 2'd0, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic load3(input int a, input int b, input int c);
    sym_buf[sym_len]   = 2'(a);
    sym_buf[sym_len+1] = 2'(b);
    sym_buf[sym_len+2] = 2'(c);
    sym_len += 3;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int h0, d0, g;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_hit_cnt", 32'(hit_cnt), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Lane 1: 1,2,3,0,1,2,3 -> two hits, count 2.
    sym_len = 0; load3(1, 2, 3); sym_buf[3] = 2'd0; sym_len = 4; load3(1, 2, 3);
    h0 = mon_hits; d0 = mon_dones;
    run_burst(1, 1'b0);
    check("t1_hits", 32'(mon_hits - h0), 32'd2);
    check("t1_dones", 32'(mon_dones - d0), 32'd1);
    check("t1_done_id", 32'(last_done_id), 32'd1);
    check("t1_cnt", 32'(last_cnt), 32'd2);

    // Lane 0: 1,1,2,1,2,3 -> exactly one hit.
    sym_len = 0; load3(1, 1, 2); load3(1, 2, 3);
    h0 = mon_hits;
    run_burst(0, 1'b0);
    check("t2_hits", 32'(mon_hits - h0), 32'd1);
    check("t2_cnt", 32'(last_cnt), 32'd1);
    check("t2_done_id", 32'(last_done_id), 32'd0);

    // Lane 0: 2,3 alone -> nothing.
    sym_len = 2; sym_buf[0] = 2'd2; sym_buf[1] = 2'd3;
    h0 = mon_hits;
    run_burst(0, 1'b0);
    check("t3_hits", 32'(mon_hits - h0), 32'd0);
    check("t3_cnt", 32'(last_cnt), 32'd0);

    // Abort: lane 2 takes 1,2 then drops req; search resumes at lane 3.
    d0 = mon_dones;
    req = 4'b0100;
    set_inputs(2, 1'b0, 2'd0, 1'b0);
    wait_any(g);
    check("ab_lane", 32'(g), 32'd2);
    set_inputs(2, 1'b1, 2'd1, 1'b0); @(negedge clk);
    set_inputs(2, 1'b1, 2'd2, 1'b0); @(negedge clk);
    req = 4'b1011;
    set_inputs(2, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    check("ab_gnt", 32'(gnt), 32'h0);
    check("ab_busy", 32'(busy), 32'h0);
    wait_any(g);
    check("ab_next_lane", 32'(g), 32'd3);
    set_inputs(3, 1'b1, 2'd0, 1'b1); @(negedge clk);
    req = '0;
    set_inputs(3, 1'b0, 2'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("ab_dones", 32'(mon_dones - d0), 32'd1);
    check("ab_done_id", 32'(last_done_id), 32'd3);

    // Saturation: five patterns with vld gaps inside them.
    sym_len = 0;
    for (int i = 0; i < 5; i++) load3(1, 2, 3);
    h0 = mon_hits;
    run_burst(3, 1'b1);
    check("sat_hits", 32'(mon_hits - h0), 32'd5);
    check("sat_cnt4", 32'(last_cnt), 32'd5);
    check("sat_cnt2", 32'(last_s_cnt), 32'd3);

    // Reset in the middle of a lane-1 burst.
    req = 4'b0010;
    set_inputs(1, 1'b0, 2'd0, 1'b0);
    wait_any(g);
    check("mr_lane", 32'(g), 32'd1);
    set_inputs(1, 1'b1, 2'd1, 1'b0); @(negedge clk);
    set_inputs(1, 1'b1, 2'd2, 1'b0); @(negedge clk);
    set_inputs(1, 1'b1, 2'd3, 1'b0); @(negedge clk);
    check("mr_hit_before", 32'(hit), 32'd1);
    check("mr_cnt_before", 32'(hit_cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_gnt", 32'(gnt), 32'h0);
    check("mr_busy", 32'(busy), 32'h0);
    check("mr_hit", 32'(hit), 32'h0);
    check("mr_done", 32'(done), 32'h0);
    check("mr_cnt", 32'(hit_cnt), 32'h0);
    check("mr_sat_cnt", 32'(s_hit_cnt), 32'h0);
    req = '0;
    set_inputs(0, 1'b0, 2'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req   = 4'hF;

    // Round robin with all lanes requesting, single-symbol bursts.
    for (int k = 0; k < 5; k++) begin
      wait_any(g);
      check("rr_gnt", 32'(gnt), 32'(1 << (k % N)));
      if (g < 0) break;
      set_inputs(g, 1'b1, 2'($urandom), 1'b1); @(negedge clk);
      set_inputs(g, 1'b0, 2'd0, 1'b0);
    end
    req = '0;
    repeat (4) @(negedge clk);

    // Random traffic checked by the model.
    for (int c = 0; c < 600; c++) begin
      for (int l = 0; l < N; l++) begin
        if ($urandom_range(0, 9) == 0) req[l] = ~req[l];
        last[l] = ($urandom_range(0, 4) == 0);
      end
      vld = N'($urandom);
      num = NW'($urandom);
      @(negedge clk);
    end
    req = '0; vld = '0; last = '0;
    repeat (6) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_arbiter.md
Name: seq_detect_arbiter

Overview:
- Shares one 1→2→3 symbol-sequence detector among N requesters.
- Grants the detector round-robin for one burst at a time and runs the detector on the granted lane's 2-bit symbols.
- Reports the number of completed 1,2,3 patterns at end of burst.
- Sits between the symbol-producing lanes and the status/consumer logic.

Parameters:
- N, 4, number of requester lanes (2..8).
- IDW, 2, width of lane index; must satisfy 2^IDW >= N.
- CNTW, 4, width of per-burst hit counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  N  per-lane request; held high for whole burst
- vld  in  N  per-lane symbol valid
- num  in  2*N  per-lane symbol; lane i uses bits [2i+1:2i]
- last  in  N  per-lane end-of-burst marker, qualified by vld
- gnt  out  N  one-hot grant, registered
- busy  out  1  high in RUN and REPORT
- hit  out  1  one-cycle pulse when a 1,2,3 pattern completes
- done  out  1  one-cycle pulse at end of a completed burst
- done_id  out  IDW  index of the lane that finished; valid with done
- hit_cnt  out  CNTW  hits counted in the burst; valid with done, held until next grant

Behaviour:
- Reset (rst_n low, any time, including mid-burst):
  - FSM to IDLE, rr pointer 0, detector S0.
  - gnt, hit, done, busy, done_id, hit_cnt all 0 immediately.
- Control FSM states: IDLE, RUN, REPORT.
- IDLE:
  - If req != 0, pick the first set req bit searching from pointer p upward, wrapping at N-1→0.
  - Next cycle: gnt one-hot for that lane g, state RUN, detector S0, hit_cnt 0.
  - Latency: req sampled at edge t, gnt visible after edge t.
- RUN, on each edge where vld[g] is 1:
  - Detector consumes num[g].
  - If last[g] is also 1, state goes to REPORT.
  - vld/last on non-granted lanes are ignored.
  - Cycles with vld[g]=0 hold all state.
- RUN abort: if req[g] drops while vld[g]=0, return to IDLE with:
  - gnt cleared, no done pulse, p <= g+1 mod N.
  - Any symbol accepted in that cycle is discarded.
- REPORT (exactly one cycle):
  - done=1, done_id=g, hit_cnt final, gnt=0, busy=1.
  - p <= g+1 mod N.
  - Next state IDLE; new grant earliest two edges after REPORT.
- Detector, per accepted symbol:
  - S0: num==1→S1, else S0.
  - S1: num==2→S2; num==1→S1; else S0.
  - S2: num==3→S3; num==1→S1; else S0.
  - S3: num==1→S1, else S0. S3 is not sticky, so back-to-back patterns count.
- Hit:
  - Registered pulse on the edge the detector enters S3; visible in the following cycle.
  - hit_cnt increments on the same edge and saturates at 2^CNTW-1.
- Last symbol completes a pattern: hit pulses and the counted value is included in the REPORT-cycle hit_cnt (same edge).
- Pointer wrap: lane N-1 finishing sets p=0.
- Requesters are never preempted mid-burst.
- Simultaneous requests: only the rr winner is granted; the others wait and are not dropped.
- hit_cnt and done_id hold their values after REPORT until the next grant clears hit_cnt.

Test Plan:
- Reset mid-RUN: assert rst_n=0 with gnt=0010 → gnt, busy, hit, done, hit_cnt all 0 asynchronously; after release, first grant goes to lowest requesting lane from p=0.
- Single burst, lane 1: symbols 1,2,3,0,1,2,3 (last on final) → hit pulses twice; done=1, done_id=1, hit_cnt=2.
- Overlap/restart, lane 0: symbols 1,1,2,1,2,3 → exactly one hit, on the 6th symbol; 2,3 alone → no hit.
- Round-robin with req=1111 held:
  - Successive single-symbol bursts grant lanes 0,1,2,3,0 in order.
  - Foreign vld/num during a burst has no effect.
- Abort: lane 2 granted, symbols 1,2, then req[2]=0 → IDLE, no done; next grant search starts at lane 3.
- Saturation with CNTW=2: five 1,2,3 patterns → hit_cnt=3 at done; gaps with vld[g]=0 inside a pattern still yield hits.
